// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_fetch_unit: PC owner, ROM address driver and fetch queue to decode.  |
// | Optional macro FETCH_PERF_CNT_EN adds saturating performance counters.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module instr_fetch_unit #(
   parameter logic [63:0] RESET_PC   = 64'h0,
   parameter int          FQ_DEPTH   = 4,
   parameter int          IMEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        dec_valid,
   output logic [31:0] dec_instr,
   output logic [63:0] dec_pc,
   input  logic        dec_ready,
   output logic        fetch_halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_fq_full,
   output logic [31:0] perf_redirects
`endif
);

   localparam int                 c_PTR_W = $clog2(FQ_DEPTH);
   localparam int                 c_CNT_W = c_PTR_W + 1;
   localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(FQ_DEPTH);
   localparam logic [c_PTR_W-1:0] c_PTR_1 = c_PTR_W'(1);
   localparam logic [c_CNT_W-1:0] c_CNT_1 = c_CNT_W'(1);

   logic [63:0]        r_pc;
   logic [c_PTR_W-1:0] r_head;
   logic [c_PTR_W-1:0] r_tail;
   logic [c_CNT_W-1:0] r_count;
   logic [63:0]        r_q_pc    [FQ_DEPTH];
   logic [31:0]        r_q_instr [FQ_DEPTH];

   logic        w_oob;
   logic        w_pop;
   logic        w_push;
   logic [63:0] w_redirect_target;

   assign w_oob             = (r_pc + 64'd3) >= 64'(IMEM_BYTES);
   assign w_pop             = dec_valid && dec_ready;
   assign w_push            = !redirect_valid && !w_oob && ((r_count != c_FULL) || w_pop);
   assign w_redirect_target = redirect_pc & ~64'h3;

   assign imem_addr    = r_pc;
   assign fetch_halted = w_oob;
   assign dec_valid    = (r_count != '0);
   assign dec_pc       = dec_valid ? r_q_pc[r_head]    : 64'h0;
   assign dec_instr    = dec_valid ? r_q_instr[r_head] : 32'h0;

   // Redirect wins over everything; a pop in that cycle still counts as delivered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pc    <= RESET_PC;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (redirect_valid) begin
         r_pc    <= w_redirect_target;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_pc   <= r_pc + 64'd4;
            r_tail <= r_tail + c_PTR_1;
         end
         if (w_pop) begin
            r_head <= r_head + c_PTR_1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_1;
            2'b01:   r_count <= r_count - c_CNT_1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FQ_DEPTH; i++) begin
            r_q_pc[i]    <= 64'h0;
            r_q_instr[i] <= 32'h0;
         end
      end else if (w_push) begin
         r_q_pc[r_tail]    <= r_pc;
         r_q_instr[r_tail] <= imem_instr;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_perf_fetched;
   logic [31:0] r_perf_fq_full;
   logic [31:0] r_perf_redirects;
   logic        w_full_stall;

   assign w_full_stall   = (r_count == c_FULL) && !w_pop;
   assign perf_fetched   = r_perf_fetched;
   assign perf_fq_full   = r_perf_fq_full;
   assign perf_redirects = r_perf_redirects;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_perf_fetched   <= 32'h0;
         r_perf_fq_full   <= 32'h0;
         r_perf_redirects <= 32'h0;
      end else begin
         if (w_push && (r_perf_fetched != 32'hFFFF_FFFF)) begin
            r_perf_fetched <= r_perf_fetched + 32'd1;
         end
         if (w_full_stall && (r_perf_fq_full != 32'hFFFF_FFFF)) begin
            r_perf_fq_full <= r_perf_fq_full + 32'd1;
         end
         if (redirect_valid && (r_perf_redirects != 32'hFFFF_FFFF)) begin
            r_perf_redirects <= r_perf_redirects + 32'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// Bench for instr_fetch_unit: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_instr_fetch_unit;
   localparam int DEPTH     = 4;
   localparam int ROM_BYTES = 1024;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [63:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        dec_valid;
   logic [31:0] dec_instr;
   logic [63:0] dec_pc;
   logic        dec_ready;
   logic        fetch_halted;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_fq_full, perf_redirects;
`endif

   always #5 clk = ~clk;

   logic [31:0] rom [ROM_BYTES/4];
   assign imem_instr = (imem_addr < 64'(ROM_BYTES)) ? rom[imem_addr[9:2]] : 32'h0;

   instr_fetch_unit #(.RESET_PC(64'h0), .FQ_DEPTH(DEPTH), .IMEM_BYTES(ROM_BYTES)) dut (
      .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc),
      .dec_ready(dec_ready), .fetch_halted(fetch_halted)
`ifdef FETCH_PERF_CNT_EN
      , .perf_fetched(perf_fetched), .perf_fq_full(perf_fq_full), .perf_redirects(perf_redirects)
`endif
   );

   int errors = 0;
   int checks = 0;

   typedef struct packed { logic [63:0] pc; logic [31:0] instr; } entry_t;
   entry_t      m_q[$];
   logic [63:0] m_pc;
   int unsigned m_fetched, m_full, m_redirects;

   function automatic logic [31:0] rom_word(input logic [63:0] a);
      return (a < 64'(ROM_BYTES)) ? rom[a[9:2]] : 32'h0;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_pc        = 64'h0;
      m_fetched   = 0;
      m_full      = 0;
      m_redirects = 0;
   endtask

   // Advance the reference model by one clock using the currently driven inputs,
   // then move to 1 time unit after the next rising edge.
   task automatic tick();
      bit pop, oob, push;
      pop  = (m_q.size() != 0) && dec_ready;
      oob  = (m_pc + 64'd3) >= 64'(ROM_BYTES);
      push = !redirect_valid && !oob && ((m_q.size() < DEPTH) || pop);
      if (m_q.size() == DEPTH && !pop) m_full++;
      if (push) m_fetched++;
      if (redirect_valid) m_redirects++;
      if (redirect_valid) begin
         m_q.delete();
         m_pc = {redirect_pc[63:2], 2'b00};
      end else begin
         if (pop) void'(m_q.pop_front());
         if (push) begin
            m_q.push_back('{pc: m_pc, instr: rom_word(m_pc)});
            m_pc = m_pc + 64'd4;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset_n        = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 64'h0;
      dec_ready      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid: got %0b expected 0", dec_valid); end
      checks++; if (dec_pc !== 64'h0) begin errors++; $display("FAIL reset_dec_pc: got %h expected 0", dec_pc); end
      checks++; if (dec_instr !== 32'h0) begin errors++; $display("FAIL reset_dec_instr: got %h expected 0", dec_instr); end
      checks++; if (imem_addr !== 64'h0) begin errors++; $display("FAIL reset_imem_addr: got %h expected 0", imem_addr); end
      checks++; if (fetch_halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b expected 0", fetch_halted); end
   endtask

   task automatic test_stream();
      apply_reset();
      dec_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++; if (imem_addr !== 64'(4 * i)) begin errors++; $display("FAIL stream_addr%0d: got %h expected %h", i, imem_addr, 64'(4 * i)); end
         if (i > 0) begin
            checks++;
            if (dec_valid !== 1'b1 || dec_pc !== 64'(4 * (i - 1)) || dec_instr !== 32'(i - 1)) begin
               errors++;
               $display("FAIL stream_dec%0d: got v=%0b pc=%h instr=%h expected v=1 pc=%h instr=%h", i, dec_valid, dec_pc, dec_instr, 64'(4 * (i - 1)), 32'(i - 1));
            end
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      repeat (6) tick();
      checks++; if (imem_addr !== 64'd16) begin errors++; $display("FAIL bp_addr: got %h expected 10", imem_addr); end
      checks++; if (dec_valid !== 1'b1 || dec_pc !== 64'h0) begin errors++; $display("FAIL bp_head: got v=%0b pc=%h expected v=1 pc=0", dec_valid, dec_pc); end
      repeat (4) tick();
`ifdef FETCH_PERF_CNT_EN
      checks++;
      if (perf_fetched !== 32'd4 || perf_fq_full !== 32'd6 || perf_redirects !== 32'd0) begin
         errors++;
         $display("FAIL bp_perf: got fetched=%0d full=%0d redir=%0d expected 4 6 0", perf_fetched, perf_fq_full, perf_redirects);
      end
`endif
      dec_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (dec_valid !== 1'b1 || dec_pc !== 64'(4 * k)) begin
            errors++;
            $display("FAIL bp_drain%0d: got v=%0b pc=%h expected v=1 pc=%h", k, dec_valid, dec_pc, 64'(4 * k));
         end
         tick();
      end
   endtask

   task automatic test_redirect();
      dec_ready = 1'b0;
      repeat (2) tick();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h42;
      tick();
      redirect_valid = 1'b0;
      checks++; if (dec_valid !== 1'b0 || imem_addr !== 64'h40) begin errors++; $display("FAIL redir_flush: got v=%0b addr=%h expected v=0 addr=40", dec_valid, imem_addr); end
      tick();
      checks++;
      if (dec_valid !== 1'b1 || dec_pc !== 64'h40 || dec_instr !== 32'h10) begin
         errors++;
         $display("FAIL redir_target: got v=%0b pc=%h instr=%h expected v=1 pc=40 instr=10", dec_valid, dec_pc, dec_instr);
      end
   endtask

   task automatic test_halt();
      dec_ready      = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h3F8;
      tick();
      redirect_valid = 1'b0;
      checks++; if (imem_addr !== 64'h3F8 || fetch_halted !== 1'b0) begin errors++; $display("FAIL halt_start: got addr=%h h=%0b expected addr=3f8 h=0", imem_addr, fetch_halted); end
      repeat (2) tick();
      checks++; if (imem_addr !== 64'h400 || fetch_halted !== 1'b1) begin errors++; $display("FAIL halt_enter: got addr=%h h=%0b expected addr=400 h=1", imem_addr, fetch_halted); end
      repeat (2) tick();
      checks++; if (imem_addr !== 64'h400 || dec_pc !== 64'h3F8) begin errors++; $display("FAIL halt_hold: got addr=%h pc=%h expected addr=400 pc=3f8", imem_addr, dec_pc); end
      dec_ready = 1'b1;
      checks++; if (dec_valid !== 1'b1 || dec_instr !== 32'hFE) begin errors++; $display("FAIL halt_drain0: got v=%0b instr=%h expected v=1 instr=fe", dec_valid, dec_instr); end
      tick();
      checks++; if (dec_valid !== 1'b1 || dec_pc !== 64'h3FC || dec_instr !== 32'hFF) begin errors++; $display("FAIL halt_drain1: got v=%0b pc=%h instr=%h expected v=1 pc=3fc instr=ff", dec_valid, dec_pc, dec_instr); end
      tick();
      checks++; if (dec_valid !== 1'b0 || fetch_halted !== 1'b1) begin errors++; $display("FAIL halt_empty: got v=%0b h=%0b expected v=0 h=1", dec_valid, fetch_halted); end
      redirect_valid = 1'b1;
      redirect_pc    = 64'h0;
      tick();
      redirect_valid = 1'b0;
      checks++; if (fetch_halted !== 1'b0 || imem_addr !== 64'h0) begin errors++; $display("FAIL halt_exit: got h=%0b addr=%h expected h=0 addr=0", fetch_halted, imem_addr); end
   endtask

   task automatic test_async_reset();
      apply_reset();
      repeat (3) tick();
      checks++; if (dec_valid !== 1'b1 || imem_addr !== 64'hC) begin errors++; $display("FAIL areset_pre: got v=%0b addr=%h expected v=1 addr=c", dec_valid, imem_addr); end
      #2;
      reset_n = 1'b0;
      #1;
      checks++; if (dec_valid !== 1'b0 || imem_addr !== 64'h0) begin errors++; $display("FAIL areset_now: got v=%0b addr=%h expected v=0 addr=0", dec_valid, imem_addr); end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      model_reset();
      dec_ready = 1'b1;
      rom[0] = 32'hA5A5_0000;
      tick();
      checks++;
      if (dec_valid !== 1'b1 || dec_pc !== 64'h0 || dec_instr !== 32'hA5A5_0000 || imem_addr !== 64'h4) begin
         errors++;
         $display("FAIL areset_refetch: got v=%0b pc=%h instr=%h addr=%h expected v=1 pc=0 instr=a5a50000 addr=4", dec_valid, dec_pc, dec_instr, imem_addr);
      end
   endtask

   task automatic test_random();
      logic        ev, eh, bad;
      logic [63:0] epc;
      logic [31:0] ein;
      for (int i = 0; i < ROM_BYTES / 4; i++) rom[i] = $urandom;
      apply_reset();
      for (int c = 0; c < 800; c++) begin
         dec_ready      = ($urandom_range(0, 9) < 7);
         redirect_valid = ($urandom_range(0, 15) == 0);
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: redirect_pc = 64'($urandom_range(0, ROM_BYTES - 1));
            6, 7:             redirect_pc = 64'(ROM_BYTES - 32 + $urandom_range(0, 31));
            8:                redirect_pc = {$urandom, $urandom};
            default:          redirect_pc = 64'(ROM_BYTES + $urandom_range(0, 15));
         endcase
         tick();
         ev  = (m_q.size() != 0);
         eh  = (m_pc + 64'd3) >= 64'(ROM_BYTES);
         epc = ev ? m_q[0].pc : 64'h0;
         ein = ev ? m_q[0].instr : 32'h0;
         bad = (dec_valid !== ev) || (imem_addr !== m_pc) || (fetch_halted !== eh) ||
               (ev && ((dec_pc !== epc) || (dec_instr !== ein)));
         checks++;
         if (bad) begin
            errors++;
            $display("FAIL rand_cycle%0d: got v=%0b pc=%h instr=%h addr=%h h=%0b expected v=%0b pc=%h instr=%h addr=%h h=%0b",
                     c, dec_valid, dec_pc, dec_instr, imem_addr, fetch_halted, ev, epc, ein, m_pc, eh);
         end
      end
      redirect_valid = 1'b0;
`ifdef FETCH_PERF_CNT_EN
      checks++;
      if (perf_fetched !== 32'(m_fetched) || perf_fq_full !== 32'(m_full) || perf_redirects !== 32'(m_redirects)) begin
         errors++;
         $display("FAIL rand_perf: got %0d %0d %0d expected %0d %0d %0d", perf_fetched, perf_fq_full, perf_redirects, m_fetched, m_full, m_redirects);
      end
`endif
   endtask

   initial begin
      for (int i = 0; i < ROM_BYTES / 4; i++) rom[i] = 32'(i);
      reset_n        = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 64'h0;
      dec_ready      = 1'b0;
      model_reset();
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_halt();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
